// File: rtl/cnt_slot_arbiter.sv
// Round-robin arbiter that time-shares one up-counter among NREQ requesters.
// Optional early abort on request drop is enabled by defining CNT_SLOT_ABORT_EN.
module cnt_slot_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] start_val,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [CNT_W-1:0]      counter,
  output logic                  y,
  output logic [NREQ-1:0]       done
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic [CNT_W-1:0]   counter_q, counter_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   winner_q, winner_d;

  logic [CNT_W-1:0]   sv_arr [NREQ];
  logic               found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   next_ptr;
  logic               abort_hit;
  int                 idx;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      sv_arr[i] = start_val[i*CNT_W +: CNT_W];
    end
  end

  // Scan from ptr upward with wrap; the first requesting index wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = PTR_W'(idx);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign next_ptr = (winner_q == PTR_W'(NREQ - 1)) ? '0 : winner_q + 1'b1;

`ifdef CNT_SLOT_ABORT_EN
  assign abort_hit = (state_q == S_COUNT) && !req[winner_q];
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = done_q;
    counter_d = counter_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    winner_d  = winner_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d          = S_COUNT;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          counter_d        = sv_arr[win_idx];
          busy_d           = 1'b1;
          winner_d         = win_idx;
        end
      end
      S_COUNT: begin
        if (abort_hit) begin
          state_d   = S_IDLE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          counter_d = '0;
          ptr_d     = next_ptr;
        end else if (counter_q == MAX) begin
          state_d          = S_DONE;
          gnt_d            = '0;
          busy_d           = 1'b0;
          counter_d        = '0;
          done_d           = '0;
          done_d[winner_q] = 1'b1;
          ptr_d            = next_ptr;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      S_DONE: begin
        // No arbitration here, guaranteeing one idle cycle between slots.
        state_d = S_IDLE;
        done_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      counter_q <= '0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      winner_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      counter_q <= counter_d;
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign counter = counter_q;
  assign busy    = busy_q;
  assign y       = (state_q == S_COUNT) && (counter_q == MAX);

endmodule

// File: tb/tb_cnt_slot_arbiter.sv
// Directed self-checking bench for cnt_slot_arbiter (NREQ=4, CNT_W=3).
module tb_cnt_slot_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [11:0] start_val;
  logic [3:0]  gnt;
  logic        busy;
  logic [2:0]  counter;
  logic        y;
  logic [3:0]  done;

  int checks = 0;
  int passed = 0;

  cnt_slot_arbiter #(.NREQ(4), .CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .start_val (start_val),
    .gnt       (gnt),
    .busy      (busy),
    .counter   (counter),
    .y         (y),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic checkAll(input string tag, input logic [3:0] e_gnt, input logic [2:0] e_cnt,
                          input logic e_busy, input logic e_y, input logic [3:0] e_done);
    checkOutput({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
    checkOutput({tag, ".counter"}, 32'(counter), 32'(e_cnt));
    checkOutput({tag, ".busy"},    32'(busy),    32'(e_busy));
    checkOutput({tag, ".y"},       32'(y),       32'(e_y));
    checkOutput({tag, ".done"},    32'(done),    32'(e_done));
  endtask

  task automatic doReset();
    reset = 1'b1;
    req   = 4'b0000;
    applyStimulus(2);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req       = 4'b0000;
    start_val = '0;
    #1;

    // T1: single slot from start value 5
    doReset();
    checkAll("t1_reset", 4'b0000, 3'd0, 1'b0, 1'b0, 4'b0000);
    req = 4'b0001;
    start_val = {3'd0, 3'd0, 3'd0, 3'd5};
    applyStimulus(1);
    checkAll("t1_grant", 4'b0001, 3'd5, 1'b1, 1'b0, 4'b0000);
    req = 4'b0000;
    applyStimulus(1);
    checkAll("t1_c6", 4'b0001, 3'd6, 1'b1, 1'b0, 4'b0000);
    applyStimulus(1);
    checkAll("t1_c7", 4'b0001, 3'd7, 1'b1, 1'b1, 4'b0000);
    applyStimulus(1);
    checkAll("t1_done", 4'b0000, 3'd0, 1'b0, 1'b0, 4'b0001);
    applyStimulus(1);
    checkAll("t1_idle", 4'b0000, 3'd0, 1'b0, 1'b0, 4'b0000);

    // T3: ptr=1 after slot 0, req=0101 -> requester 2 wins
    req = 4'b0101;
    start_val = {3'd0, 3'd6, 3'd0, 3'd0};
    applyStimulus(1);
    checkAll("t3_grant", 4'b0100, 3'd6, 1'b1, 1'b0, 4'b0000);
    req = 4'b0000;
    applyStimulus(1);
    checkAll("t3_c7", 4'b0100, 3'd7, 1'b1, 1'b1, 4'b0000);
    applyStimulus(1);
    checkAll("t3_done", 4'b0000, 3'd0, 1'b0, 1'b0, 4'b0100);

    // T2: all requesting with start 7 -> strict rotation, one COUNT cycle each
    doReset();
    req = 4'b1111;
    start_val = {3'd7, 3'd7, 3'd7, 3'd7};
    applyStimulus(1);
    checkAll("t2_g0", 4'b0001, 3'd7, 1'b1, 1'b1, 4'b0000);
    applyStimulus(1);
    checkAll("t2_d0", 4'b0000, 3'd0, 1'b0, 1'b0, 4'b0001);
    applyStimulus(1);
    checkAll("t2_gap0", 4'b0000, 3'd0, 1'b0, 1'b0, 4'b0000);
    applyStimulus(1);
    checkAll("t2_g1", 4'b0010, 3'd7, 1'b1, 1'b1, 4'b0000);
    applyStimulus(1);
    checkAll("t2_d1", 4'b0000, 3'd0, 1'b0, 1'b0, 4'b0010);
    applyStimulus(2);
    checkAll("t2_g2", 4'b0100, 3'd7, 1'b1, 1'b1, 4'b0000);
    applyStimulus(1);
    checkAll("t2_d2", 4'b0000, 3'd0, 1'b0, 1'b0, 4'b0100);
    applyStimulus(2);
    checkAll("t2_g3", 4'b1000, 3'd7, 1'b1, 1'b1, 4'b0000);
    applyStimulus(1);
    checkAll("t2_d3", 4'b0000, 3'd0, 1'b0, 1'b0, 4'b1000);
    applyStimulus(2);
    checkAll("t2_g0b", 4'b0001, 3'd7, 1'b1, 1'b1, 4'b0000);

    // T4: reset mid-COUNT suppresses done and restores ptr=0
    doReset();
    req = 4'b0010;
    start_val = {3'd0, 3'd0, 3'd2, 3'd0};
    applyStimulus(1);
    checkAll("t4_grant", 4'b0010, 3'd2, 1'b1, 1'b0, 4'b0000);
    applyStimulus(2);
    checkAll("t4_c4", 4'b0010, 3'd4, 1'b1, 1'b0, 4'b0000);
    reset = 1'b1;
    applyStimulus(1);
    checkAll("t4_rst", 4'b0000, 3'd0, 1'b0, 1'b0, 4'b0000);
    reset = 1'b0;
    req = 4'b1111;
    start_val = {3'd1, 3'd1, 3'd1, 3'd1};
    applyStimulus(1);
    checkAll("t4_regrant", 4'b0001, 3'd1, 1'b1, 1'b0, 4'b0000);

    // T5/T6: drop req[2] at counter=3 with req[3] raised
    doReset();
    req = 4'b0100;
    start_val = {3'd0, 3'd0, 3'd0, 3'd0};
    applyStimulus(1);
    checkAll("t56_grant", 4'b0100, 3'd0, 1'b1, 1'b0, 4'b0000);
    applyStimulus(3);
    checkAll("t56_c3", 4'b0100, 3'd3, 1'b1, 1'b0, 4'b0000);
    req = 4'b1000;
    start_val = {3'd6, 3'd5, 3'd5, 3'd5};
`ifdef CNT_SLOT_ABORT_EN
    applyStimulus(1);
    checkAll("t5_abort", 4'b0000, 3'd0, 1'b0, 1'b0, 4'b0000);
    applyStimulus(1);
    checkAll("t5_next", 4'b1000, 3'd6, 1'b1, 1'b0, 4'b0000);
`else
    applyStimulus(1);
    checkAll("t6_c4", 4'b0100, 3'd4, 1'b1, 1'b0, 4'b0000);
    applyStimulus(3);
    checkAll("t6_c7", 4'b0100, 3'd7, 1'b1, 1'b1, 4'b0000);
    applyStimulus(1);
    checkAll("t6_done", 4'b0000, 3'd0, 1'b0, 1'b0, 4'b0100);
    applyStimulus(1);
    checkAll("t6_gap", 4'b0000, 3'd0, 1'b0, 1'b0, 4'b0000);
    applyStimulus(1);
    checkAll("t6_next", 4'b1000, 3'd6, 1'b1, 1'b0, 4'b0000);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
